// File: rtl/flight_pkg.sv
// flight_pkg: constants, button bit indices and handshake states shared by the flight-control blocks
package flight_pkg;
  localparam int ANGLE_WIDTH = 16;
  localparam int COORD_WIDTH = 32;
  localparam int NUM_BTNS = 6;
  localparam int BTN_PITCH_UP = 0;
  localparam int BTN_PITCH_DOWN = 1;
  localparam int BTN_ROLL_LEFT = 2;
  localparam int BTN_ROLL_RIGHT = 3;
  localparam int BTN_THR_UP = 4;
  localparam int BTN_THR_DOWN = 5;
  typedef enum logic {IDLE, HOLD} hs_state_e;
endpackage

// File: rtl/debouncer.sv
// debouncer: 2-FF synchroniser followed by a stable-count filter on one button
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1_q, sync2_q, level_q, level_d, differ, done;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    differ = sync2_q != level_q;
    done = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = (differ && !done) ? cnt_q + 1'b1 : '0;
    level_d = done ? sync2_q : level_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q <= cnt_d;
      level_q <= level_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/pilot_input_ctrl.sv
// pilot_input_ctrl: debounced buttons -> tick-ramped pitch/roll/throttle, snapshotted over request/ready
module pilot_input_ctrl #(
  parameter int ANGLE_WIDTH = flight_pkg::ANGLE_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES = 5000000,
  parameter int RATE_STEP = 5,
  parameter int RATE_MAX = 45,
  parameter int THROTTLE_STEP = 1,
  parameter int THROTTLE_MAX = 100,
  parameter int THROTTLE_INIT = 0,
  parameter int AUTO_CENTER = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [5:0]                    btn_raw,
  input  logic                          request_input,
  output logic                          input_ready,
  output logic signed [ANGLE_WIDTH-1:0] pitch_change,
  output logic signed [ANGLE_WIDTH-1:0] roll_change,
  output logic [7:0]                    throttle,
  output logic [5:0]                    btn_state
);
  import flight_pkg::*;
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam logic signed [ANGLE_WIDTH:0] R_STEP = (ANGLE_WIDTH + 1)'(RATE_STEP);
  localparam logic signed [ANGLE_WIDTH:0] R_MAX = (ANGLE_WIDTH + 1)'(RATE_MAX);
  localparam logic [8:0] T_STEP = 9'(THROTTLE_STEP);
  localparam logic [8:0] T_MAX = 9'(THROTTLE_MAX);
  localparam logic [8:0] T_INIT = 9'(THROTTLE_INIT);

  // Working values carry one spare bit so the step never wraps before clamping.
  function automatic logic signed [ANGLE_WIDTH:0] axis_next(logic pos, logic neg,
                                                            logic signed [ANGLE_WIDTH:0] v);
    logic signed [ANGLE_WIDTH:0] up, dn;
    up = v + R_STEP;
    dn = v - R_STEP;
    if (pos && !neg) return up > R_MAX ? R_MAX : up;
    if (neg && !pos) return dn < -R_MAX ? -R_MAX : dn;
    if (AUTO_CENTER == 0) return v;
    if (v > 0) return v > R_STEP ? dn : '0;
    return v < -R_STEP ? up : '0;
  endfunction

  function automatic logic [8:0] thr_next(logic up_btn, logic dn_btn, logic [8:0] t);
    logic [8:0] up;
    up = t + T_STEP;
    return (up_btn && !dn_btn) ? (up > T_MAX ? T_MAX : up) :
           (dn_btn && !up_btn) ? (t < T_STEP ? 9'd0 : t - T_STEP) : t;
  endfunction

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .reset(reset),
      .raw(btn_raw[i]),
      .level(btn_state[i])
    );
  end

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic tick;
  logic signed [ANGLE_WIDTH:0] pitch_q, pitch_d, roll_q, roll_d;
  logic [8:0] thr_q, thr_d;
  hs_state_e state_q;

  always_comb begin
    tick = tick_cnt_q == TW'(TICK_CYCLES - 1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pitch_d = tick ? axis_next(btn_state[BTN_PITCH_UP], btn_state[BTN_PITCH_DOWN], pitch_q) : pitch_q;
    roll_d = tick ? axis_next(btn_state[BTN_ROLL_RIGHT], btn_state[BTN_ROLL_LEFT], roll_q) : roll_q;
    thr_d = tick ? thr_next(btn_state[BTN_THR_UP], btn_state[BTN_THR_DOWN], thr_q) : thr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      pitch_q <= '0;
      roll_q <= '0;
      thr_q <= T_INIT;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pitch_q <= pitch_d;
      roll_q <= roll_d;
      thr_q <= thr_d;
    end
  end

  // Snapshot reads the registered working values, so a coincident tick lands in the next handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      input_ready <= 1'b0;
      pitch_change <= '0;
      roll_change <= '0;
      throttle <= T_INIT[7:0];
    end else if (state_q == IDLE && request_input) begin
      state_q <= HOLD;
      input_ready <= 1'b1;
      pitch_change <= pitch_q[ANGLE_WIDTH-1:0];
      roll_change <= roll_q[ANGLE_WIDTH-1:0];
      throttle <= thr_q[7:0];
    end else if (state_q == HOLD && !request_input) begin
      state_q <= IDLE;
      input_ready <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pilot_input_ctrl.sv
// tb_pilot_input_ctrl: random and directed stimulus on two configurations, scoreboarded snapshots
module tb_pilot_input_ctrl;
  localparam int D = 4, T = 8, S = 5, M = 45, TS = 1, TM = 100;
  localparam int INIT[2] = '{98, 0};
  localparam bit AC[2] = '{1'b1, 1'b0};

  logic clk = 1'b0, reset = 1'b1, request_input = 1'b0;
  logic [5:0] btn_raw = '0;
  logic ready_a, ready_b;
  logic signed [15:0] pa, ra, pb, rb;
  logic [7:0] ta, tb;
  logic [5:0] bs_a, bs_b;

  always #5 clk = ~clk;

  pilot_input_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T), .AUTO_CENTER(1), .THROTTLE_INIT(98)) dut_a (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .request_input(request_input),
    .input_ready(ready_a), .pitch_change(pa), .roll_change(ra), .throttle(ta), .btn_state(bs_a));
  pilot_input_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T), .AUTO_CENTER(0), .THROTTLE_INIT(0)) dut_b (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .request_input(request_input),
    .input_ready(ready_b), .pitch_change(pb), .roll_change(rb), .throttle(tb), .btn_state(bs_b));

  int total = 0, bad = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {int p0, r0, t0, p1, r1, t1;} snap_t;
  snap_t sbq[$];

  function automatic int ramp(int v, bit pos, bit neg, bit ac);
    if (pos != neg) return pos ? ((v + S > M) ? M : v + S) : ((v - S < -M) ? -M : v - S);
    if (!ac) return v;
    return v > 0 ? ((v - S < 0) ? 0 : v - S) : ((v + S > 0) ? 0 : v + S);
  endfunction

  function automatic int thr(int v, bit up, bit dn);
    if (up == dn) return v;
    return up ? ((v + TS > TM) ? TM : v + TS) : ((v - TS < 0) ? 0 : v - TS);
  endfunction

  logic [5:0] lvl;
  logic [5:0] hist[$];
  int n;
  bit m_ready;
  int wp[2], wr[2], wt[2];

  // Reference: raw samples seen two edges late; a level flips once D such samples all disagree with it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl = '0;
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_front(6'b0);
      n = 0;
      m_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
        wp[k] = 0;
        wr[k] = 0;
        wt[k] = INIT[k];
      end
    end else begin
      if (!m_ready && request_input) begin
        sbq.push_back('{wp[0], wr[0], wt[0], wp[1], wr[1], wt[1]});
        m_ready = 1'b1;
      end else if (m_ready && !request_input) m_ready = 1'b0;
      if (n % T == T - 1)
        for (int k = 0; k < 2; k++) begin
          wp[k] = ramp(wp[k], lvl[0], lvl[1], AC[k]);
          wr[k] = ramp(wr[k], lvl[3], lvl[2], AC[k]);
          wt[k] = thr(wt[k], lvl[4], lvl[5]);
        end
      hist.push_front(btn_raw);
      void'(hist.pop_back());
      for (int b = 0; b < 6; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (hist[j][b] == lvl[b]) all_diff = 1'b0;
        if (all_diff) lvl[b] = ~lvl[b];
      end
      n++;
    end
  end

  bit prev;
  snap_t cur;

  always @(negedge clk) begin
    if (reset) prev = 1'b0;
    else begin
      chk("ready_a", ready_a, m_ready);
      chk("ready_b", ready_b, m_ready);
      chk("btn_state_a", bs_a, lvl);
      chk("btn_state_b", bs_b, lvl);
      if (ready_a && !prev) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: ready rose with no expected snapshot (t=%0t)", $time);
        end else cur = sbq.pop_front();
      end
      if (ready_a) begin
        chk("pitch_a", pa, cur.p0);
        chk("roll_a", ra, cur.r0);
        chk("thr_a", ta, cur.t0);
        chk("pitch_b", pb, cur.p1);
        chk("roll_b", rb, cur.r1);
        chk("thr_b", tb, cur.t1);
      end
      prev = ready_a;
    end
  end

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic hs(int hold, int gap);
    request_input = 1'b1;
    cyc(hold);
    request_input = 1'b0;
    cyc(gap);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready_a", ready_a, 0);
    chk("rst_ready_b", ready_b, 0);
    chk("rst_pitch_a", pa, 0);
    chk("rst_roll_a", ra, 0);
    chk("rst_thr_a", ta, 98);
    chk("rst_pitch_b", pb, 0);
    chk("rst_roll_b", rb, 0);
    chk("rst_thr_b", tb, 0);
    chk("rst_btn_a", bs_a, 0);
    chk("rst_btn_b", bs_b, 0);
  endtask

  initial begin
    #12;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    btn_raw = 6'b000001;
    repeat (28) hs(2, 2);
    btn_raw = 6'b000000;
    repeat (24) hs(2, 2);
    btn_raw[2] = 1'b1;
    cyc(3);
    btn_raw[2] = 1'b0;
    cyc(10);
    hs(2, 2);
    btn_raw[2] = 1'b1;
    cyc(10);
    btn_raw[2] = 1'b0;
    cyc(10);
    hs(2, 2);
    btn_raw = 6'b000110;
    repeat (28) hs(2, 2);
    btn_raw = 6'b010000;
    repeat (12) hs(2, 2);
    btn_raw = 6'b110000;
    repeat (6) hs(2, 2);
    btn_raw = 6'b100000;
    repeat (24) hs(2, 2);
    btn_raw = 6'b000001;
    cyc(20);
    for (int i = 0; i < T && (n % T) != T - 1; i++) cyc(1);
    request_input = 1'b1;
    cyc(3 * T);
    request_input = 1'b0;
    cyc(2);
    for (int i = 0; i < 300; i++) begin
      btn_raw = 6'($urandom);
      request_input = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
      else cyc($urandom_range(5, 40));
    end
    request_input = 1'b0;
    btn_raw = 6'b000101;
    cyc(40);
    request_input = 1'b1;
    cyc(4);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    request_input = 1'b0;
    btn_raw = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) hs(3, 3);
    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pilot_input_ctrl.md
# pilot_input_ctrl

Turns the pilot's raw push-buttons into rate-limited control inputs for `plane_state`. It drives `pitch_change`, `roll_change` and `throttle`, which the top level currently ties to constants. Each button is synchronised and debounced. Rates ramp on a fixed tick, saturate at a limit, and optionally self-centre. Values are delivered to `plane_state` over its `request_input`/`input_ready` handshake, so the outputs only change at a snapshot.

## Interface
Parameters:
- `ANGLE_WIDTH`, 16: width of the signed rate outputs (deg/sec).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a button change.
- `TICK_CYCLES`, 5000000: ramp tick period in clocks.
- `RATE_STEP`, 5: deg/sec change per tick.
- `RATE_MAX`, 45: magnitude limit for pitch and roll rates.
- `THROTTLE_STEP`, 1: percent change per tick.
- `THROTTLE_MAX`, 100: throttle ceiling (%).
- `THROTTLE_INIT`, 0: throttle value after reset.
- `AUTO_CENTER`, 1: when 1, a released axis decays toward 0 by `RATE_STEP` per tick; when 0, it holds.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset is asynchronous and active-high.
- `btn_raw`, in, 6: raw, unsynchronised, active-high buttons. Bits are {throttle_down, throttle_up, roll_right, roll_left, pitch_down, pitch_up}, bit 0 = pitch_up.
- `request_input`, in, 1: level request from `plane_state`.
- `input_ready`, out, 1: outputs valid and stable.
- `pitch_change`, out, signed `ANGLE_WIDTH`: snapshotted pitch rate.
- `roll_change`, out, signed `ANGLE_WIDTH`: snapshotted roll rate.
- `throttle`, out, 8: snapshotted throttle, 0..`THROTTLE_MAX`.
- `btn_state`, out, 6: debounced button levels, for LED debug.

## Operation
Input conditioning:
- Each `btn_raw` bit passes through a 2-FF synchroniser, then a debounce counter.
- The debounced level flips only after the synchronised value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing cycle resets the counter.

Ramp tick:
- A free-running counter counts 0..`TICK_CYCLES`-1 and pulses `tick` for one cycle on wrap.

Axis update, on `tick` only, for each of pitch and roll:
- Positive button alone: value += `RATE_STEP`, saturating at +`RATE_MAX`.
- Negative button alone: value -= `RATE_STEP`, saturating at -`RATE_MAX`.
- Both pressed or neither pressed with `AUTO_CENTER`=1: value moves toward 0 by `RATE_STEP`. It never overshoots; |value| < `RATE_STEP` goes to 0.
- Both pressed or neither pressed with `AUTO_CENTER`=0: value holds.
- Pitch positive = pitch_up. Roll positive = roll_right.

Throttle, on `tick` only:
- Up alone: += `THROTTLE_STEP`, clamped at `THROTTLE_MAX`.
- Down alone: -= `THROTTLE_STEP`, clamped at 0.
- Otherwise: holds. Throttle never auto-centres.

Arithmetic:
- Working registers are one bit wider than their outputs, so the step is computed without wrap.
- Clamping happens before write-back.

Handshake FSM, with states IDLE and HOLD:
- IDLE, `request_input`=1: on that edge, copy the working values to the output registers, set `input_ready`=1, go to HOLD.
- HOLD, `request_input`=1: stay in HOLD. Outputs and `input_ready` stay frozen even if the working values change.
- HOLD, `request_input`=0: clear `input_ready`, go to IDLE.
- Between handshakes, the outputs keep their last snapshot.

## Timing
Reset values:
- Output `pitch_change` and `roll_change` = 0; `throttle` = `THROTTLE_INIT`.
- Working pitch and roll registers = 0; working throttle register = `THROTTLE_INIT`.
- `input_ready` = 0, `btn_state` = 0, FSM = IDLE, tick and debounce counters = 0.

Latency:
- `request_input` sampled high in IDLE at edge k gives `input_ready`=1 and the new outputs after edge k (1 cycle).
- `request_input` low in HOLD gives `input_ready`=0 one cycle later.
- Button press to debounced level: 2 + `DEBOUNCE_CYCLES` cycles.

Boundary cases:
- A `tick` on the same edge as a snapshot: the snapshot takes the pre-tick working values. The update is visible at the next handshake.
- Reset mid-HOLD: `input_ready` drops asynchronously and the FSM returns to IDLE.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no `btn_state` change.

## Structure
- `flight_pkg` holds the shared constants: `ANGLE_WIDTH`, `COORD_WIDTH`, the `btn_raw` bit-index constants, and the FSM state enum.
- Sub-module `debouncer` contains the synchroniser and counter, parametrised by `DEBOUNCE_CYCLES`. It is instantiated 6 times, once per button.
- Ramp and handshake logic live in the top of this block.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `TICK_CYCLES`=8 unless noted.
- Hold pitch_up through 12 ticks -> working pitch goes 5, 10, … 45, then stays at 45. A handshake then returns `pitch_change`=45.
- Release pitch_up from 45 with `AUTO_CENTER`=1 -> 40, 35, … 0 over 9 ticks, then holds at 0. With `AUTO_CENTER`=0 it holds at 45.
- A 3-cycle glitch on `btn_raw`[2] -> `btn_state` unchanged and roll stays 0. A 10-cycle press -> `btn_state`[2]=1 exactly 6 cycles after the rising edge.
- `THROTTLE_INIT`=98, hold throttle_up for 5 ticks -> 99, 100, 100, … Both throttle buttons held -> throttle holds.
- Raise `request_input` on the same edge as a `tick` that takes pitch 10→15 -> `input_ready`=1 one cycle later with `pitch_change`=10. Outputs stay frozen while `request_input` is held over further ticks.
- Assert `reset` during HOLD -> `input_ready`=0 immediately; outputs return to 0/0/`THROTTLE_INIT` and the next request completes normally.
